// File: rtl/present_if.sv
// Handshake/bus bundle between the game logic and present_controller.
interface present_if;
   logic        startOfFrame;
   logic        presentDrop;
   logic        presentsVisible;
   logic        col_present;
   logic [10:0] presentX;
   logic [10:0] presentY;
   logic [1:0]  presentType;
   logic        presentActive;
   logic        presentCollected;

   modport slave (
      input  startOfFrame,
      input  presentDrop,
      input  presentsVisible,
      input  col_present,
      output presentX,
      output presentY,
      output presentType,
      output presentActive,
      output presentCollected
   );

   modport master (
      output startOfFrame,
      output presentDrop,
      output presentsVisible,
      output col_present,
      input  presentX,
      input  presentY,
      input  presentType,
      input  presentActive,
      input  presentCollected
   );
endinterface

// File: rtl/present_controller.sv
// Lifetime of the single falling bonus present: drop, fall per frame, park, remove.
// Optional macro PRESENT_BLINK_EN makes the present blink near the end of its landed time.
module present_controller #(
   parameter int unsigned FALL_SPEED   = 2,
   parameter int unsigned START_Y      = 0,
   parameter int unsigned FLOOR_Y      = 440,
   parameter int unsigned X_MIN        = 64,
   parameter int unsigned LAND_TIMEOUT = 300,
   parameter int unsigned BLINK_FRAMES = 120,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input logic        clk,
   input logic        resetN,
   present_if.slave   pres_io
);

   localparam int unsigned TW = $clog2(LAND_TIMEOUT + 1);

   typedef enum logic [1:0] {StIdle, StFalling, StLanded} state_e;

   state_e        state_q, state_d;
   logic [15:0]   lfsr_q, lfsr_d;
   logic [10:0]   x_q, x_d;
   logic [10:0]   y_q, y_d;
   logic [1:0]    type_q, type_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          active_q, active_d;
   logic          coll_q, coll_d;
   logic [11:0]   y_sum;

   // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign y_sum  = {1'b0, y_q} + 12'(FALL_SPEED);

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      type_d  = type_q;
      timer_d = timer_q;
      coll_d  = 1'b0;
      if (!pres_io.presentsVisible) begin
         state_d = StIdle;
      end else if (pres_io.col_present && active_q) begin
         state_d = StIdle;
         coll_d  = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (pres_io.presentDrop) begin
                  state_d = StFalling;
                  type_d  = lfsr_q[1:0];
                  x_d     = 11'(X_MIN) + {2'b00, lfsr_q[14:6]};
                  y_d     = 11'(START_Y);
               end
            end
            StFalling: begin
               if (pres_io.startOfFrame) begin
                  if (y_sum >= 12'(FLOOR_Y)) begin
                     y_d     = 11'(FLOOR_Y);
                     timer_d = '0;
                     state_d = StLanded;
                  end else begin
                     y_d = y_sum[10:0];
                  end
               end
            end
            StLanded: begin
               if (pres_io.startOfFrame) begin
                  timer_d = timer_q + 1'b1;
                  if (timer_q == TW'(LAND_TIMEOUT - 1)) state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

`ifdef PRESENT_BLINK_EN
   always_comb begin
      active_d = (state_d != StIdle);
      if (state_d == StLanded && timer_d >= TW'(LAND_TIMEOUT - BLINK_FRAMES)) begin
         active_d = ~timer_d[3];
      end
   end
`else
   logic unused_blink;
   assign unused_blink = ^BLINK_FRAMES;
   assign active_d     = (state_d != StIdle);
`endif

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q  <= StIdle;
         lfsr_q   <= LFSR_SEED;
         x_q      <= '0;
         y_q      <= 11'(START_Y);
         type_q   <= '0;
         timer_q  <= '0;
         active_q <= 1'b0;
         coll_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lfsr_q   <= lfsr_d;
         x_q      <= x_d;
         y_q      <= y_d;
         type_q   <= type_d;
         timer_q  <= timer_d;
         active_q <= active_d;
         coll_q   <= coll_d;
      end
   end

   assign pres_io.presentX         = x_q;
   assign pres_io.presentY         = y_q;
   assign pres_io.presentType      = type_q;
   assign pres_io.presentActive    = active_q;
   assign pres_io.presentCollected = coll_q;

endmodule

// File: tb/tb_present_controller.sv
// Directed vector bench for present_controller (default and PRESENT_BLINK_EN builds).
module tb_present_controller;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   present_if pif ();

   present_controller dut (
      .clk     (clk),
      .resetN  (resetN),
      .pres_io (pif)
   );

   always #5 clk = ~clk;

`ifdef PRESENT_BLINK_EN
   localparam bit BlinkOn = 1'b1;
`else
   localparam bit BlinkOn = 1'b0;
`endif

   // Reference LFSR: x^16+x^14+x^13+x^11+1, free-running from reset
   logic [15:0] m_lfsr;
   always @(posedge clk or negedge resetN) begin
      if (!resetN) m_lfsr <= 16'hACE1;
      else m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
   end

   typedef struct {
      string name;
      logic  drop, vis, col, sof;
      int    reps;
      logic  e_act, e_coll;
      int    e_y;
      int    xt;  // 0 none, 1 capture drop-edge LFSR and check, 2 check held values
   } vec_t;

   int n_cmp = 0;
   int n_fail = 0;
   int exp_x = 0;
   int exp_t = 0;
   logic [15:0] pre_lfsr;
   vec_t vecs[19];

   function automatic vec_t mk(string nm, logic d, logic v, logic c, logic s, int r,
                               logic a, logic cl, int y, int xt);
      vec_t t;
      t.name = nm; t.drop = d; t.vis = v; t.col = c; t.sof = s; t.reps = r;
      t.e_act = a; t.e_coll = cl; t.e_y = y; t.xt = xt;
      return t;
   endfunction

   task automatic chk(string nm, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic drive(logic d, logic v, logic c, logic s);
      pif.presentDrop = d;
      pif.presentsVisible = v;
      pif.col_present = c;
      pif.startOfFrame = s;
   endtask

   task automatic step(int n);
      for (int i = 0; i < n; i++) begin
         pre_lfsr = m_lfsr;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic land();
      drive(0, 0, 0, 0); step(1);
      drive(1, 1, 0, 0); step(1);
      drive(0, 1, 0, 1); step(220);
   endtask

   initial begin
      drive(0, 0, 0, 0);
      vecs[0]  = mk("drop",          1, 1, 0, 0, 1,   1, 0, 0,   1);
      vecs[1]  = mk("tick1",         0, 1, 0, 1, 1,   1, 0, 2,   0);
      vecs[2]  = mk("drop_falling",  1, 1, 0, 0, 1,   1, 0, 2,   2);
      vecs[3]  = mk("tick219",       0, 1, 0, 1, 218, 1, 0, 438, 2);
      vecs[4]  = mk("tick220_land",  0, 1, 0, 1, 1,   1, 0, 440, 2);
      vecs[5]  = mk("landed290",     0, 1, 0, 1, 290, 1, 0, 440, 0);
      vecs[6]  = mk("landed299",     0, 1, 0, 1, 9,   !BlinkOn, 0, 440, 0);
      vecs[7]  = mk("timeout",       0, 1, 0, 1, 1,   0, 0, 440, 2);
      vecs[8]  = mk("drop2",         1, 1, 0, 0, 1,   1, 0, 0,   1);
      vecs[9]  = mk("fall_to_100",   0, 1, 0, 1, 50,  1, 0, 100, 0);
      vecs[10] = mk("collide",       0, 1, 1, 0, 1,   0, 1, 100, 2);
      vecs[11] = mk("coll_clears",   0, 1, 0, 0, 1,   0, 0, 100, 2);
      vecs[12] = mk("col_idle",      0, 1, 1, 0, 1,   0, 0, 100, 0);
      vecs[13] = mk("drop3",         1, 1, 0, 0, 1,   1, 0, 0,   1);
      vecs[14] = mk("fall_to_20",    0, 1, 0, 1, 10,  1, 0, 20,  0);
      vecs[15] = mk("invisible",     0, 0, 0, 1, 1,   0, 0, 20,  0);
      vecs[16] = mk("drop_invis",    1, 0, 0, 0, 1,   0, 0, 20,  0);
      vecs[17] = mk("drop_and_sof",  1, 1, 0, 1, 1,   1, 0, 0,   1);
      vecs[18] = mk("first_move",    0, 1, 0, 1, 1,   1, 0, 2,   0);

      step(2);
      chk("rst_x", int'(pif.presentX), 0);
      chk("rst_y", int'(pif.presentY), 0);
      chk("rst_type", int'(pif.presentType), 0);
      chk("rst_active", int'(pif.presentActive), 0);
      chk("rst_coll", int'(pif.presentCollected), 0);
      resetN = 1'b1;
      step(3);

      foreach (vecs[i]) begin
         drive(vecs[i].drop, vecs[i].vis, vecs[i].col, vecs[i].sof);
         step(vecs[i].reps);
         if (vecs[i].xt == 1) begin
            exp_x = 64 + int'(pre_lfsr[14:6]);
            exp_t = int'(pre_lfsr[1:0]);
         end
         chk({vecs[i].name, "_active"}, int'(pif.presentActive), int'(vecs[i].e_act));
         chk({vecs[i].name, "_coll"}, int'(pif.presentCollected), int'(vecs[i].e_coll));
         chk({vecs[i].name, "_y"}, int'(pif.presentY), vecs[i].e_y);
         if (vecs[i].xt != 0) begin
            chk({vecs[i].name, "_x"}, int'(pif.presentX), exp_x);
            chk({vecs[i].name, "_type"}, int'(pif.presentType), exp_t);
         end
      end

      // Full landed period, checking the blink pattern frame by frame
      land();
      chk("land_y", int'(pif.presentY), 440);
      chk("land_active", int'(pif.presentActive), 1);
      for (int j = 1; j < 300; j++) begin
         logic [8:0] jv;
         jv = 9'(j);
         step(1);
         chk($sformatf("blink_t%0d", j), int'(pif.presentActive),
             (BlinkOn && j >= 180) ? int'(!jv[3]) : 1);
      end
      step(1);
      chk("blink_timeout", int'(pif.presentActive), 0);

      // Collision while the present would be in its blink-off phase
      land();
      step(184);
      drive(0, 1, 1, 0); step(1);
      chk("col_off_coll", int'(pif.presentCollected), BlinkOn ? 0 : 1);
      chk("col_off_active", int'(pif.presentActive), 0);
      drive(0, 1, 0, 0); step(1);
      chk("col_off_clear", int'(pif.presentCollected), 0);

      // Asynchronous reset while landed
      land();
      step(10);
      chk("pre_rst_active", int'(pif.presentActive), 1);
      #1 resetN = 1'b0;
      #1;
      chk("arst_x", int'(pif.presentX), 0);
      chk("arst_y", int'(pif.presentY), 0);
      chk("arst_type", int'(pif.presentType), 0);
      chk("arst_active", int'(pif.presentActive), 0);
      chk("arst_coll", int'(pif.presentCollected), 0);
      step(2);
      resetN = 1'b1;
      step(2);
      chk("post_rst_active", int'(pif.presentActive), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
